checksum_insert: RTL and testbench

Transmit-side checksum framer for the 512-bit streaming datapath. It forwards data beats unchanged and inserts one XOR checksum beat after every 4th data beat of a packet, and after the final beat of any shorter trailing group. The checksum beat carries `last` for the packet. The block sits in front of the link and is the counterpart of the receive-side checksum stripper, which removes exactly these beats.

---
 rtl/checksum_insert.sv | 120 ++++++++++++
 tb/tb_checksum_insert.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checksum_insert.sv
// Transmit-side checksum framer: forwards 512-bit data beats and inserts an XOR
// checksum beat after every 4th data beat of a packet and after the packet's final beat.
module checksum_insert (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [511:0] inp_data,
    input  logic         inp_valid,
    output logic         inp_ready,
    input  logic [63:0]  inp_keep,
    input  logic [5:0]   inp_id,
    input  logic         inp_last,
    output logic [511:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_keep,
    output logic [5:0]   out_id,
    output logic         out_last
);

    typedef enum logic {
        PASS = 1'b0,
        CSUM = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [511:0] acc;
    logic [2:0]   cnt;
    logic [2:0]   cnt_inc;
    logic         pend_last;
    logic [5:0]   pend_id;
    logic         reg_free;
    logic         in_fire;
    logic         csum_load;
    logic         group_end;

    // Bytes outside the keep mask must not disturb the checksum.
    function automatic logic [511:0] mask_beat(input logic [511:0] data,
                                               input logic [63:0]  keep);
        logic [511:0] masked;
        for (int i = 0; i < 64; i++) begin
            masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        end
        return masked;
    endfunction

    assign reg_free = !out_valid || out_ready;
    assign cnt_inc  = cnt + 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    // inp_ready depends only on state and the output register, never on inp_valid.
    always_comb begin
        state_next = state;
        inp_ready  = 1'b0;
        in_fire    = 1'b0;
        csum_load  = 1'b0;
        group_end  = 1'b0;
        case (state)
            PASS: begin
                inp_ready = reset_n && reg_free;
                in_fire   = inp_valid && inp_ready;
                group_end = in_fire && ((cnt_inc == 3'd4) || inp_last);
                if (group_end) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                csum_load = reg_free;
                if (csum_load) begin
                    state_next = PASS;
                end
            end
            default: state_next = PASS;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_keep  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            pend_last <= 1'b0;
            pend_id   <= '0;
        end else if (in_fire) begin
            out       <= inp_data;
            out_valid <= 1'b1;
            out_keep  <= inp_keep;
            out_id    <= inp_id;
            out_last  <= 1'b0;
            acc       <= acc ^ mask_beat(inp_data, inp_keep);
            cnt       <= cnt_inc;
            pend_id   <= inp_id;
            if (group_end) begin
                pend_last <= inp_last;
            end
        end else if (csum_load) begin
            out       <= acc;
            out_valid <= 1'b1;
            out_keep  <= '1;
            out_id    <= pend_id;
            out_last  <= pend_last;
            acc       <= '0;
            cnt       <= '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_checksum_insert.sv
// Self-checking bench for checksum_insert: directed packets plus randomized traffic
// compared against a packet-level reference model of the framing rules.
module tb_checksum_insert;

    logic         clock;
    logic         reset_n;
    logic [511:0] inp_data;
    logic         inp_valid;
    logic         inp_ready;
    logic [63:0]  inp_keep;
    logic [5:0]   inp_id;
    logic         inp_last;
    logic [511:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_keep;
    logic [5:0]   out_id;
    logic         out_last;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [5:0]   id;
        logic         last;
    } beat_t;

    int errors = 0;
    int checks = 0;
    beat_t        got[$];
    beat_t        exp_q[$];
    logic [511:0] s_data[$];
    logic [63:0]  s_keep[$];
    logic [5:0]   s_id[$];
    logic         s_last[$];
    bit rand_bp = 0;
    bit manual  = 0;
    bit gap_en  = 0;
    bit cnt_en  = 0;
    int low_cnt = 0;

    checksum_insert dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .inp_data  (inp_data),
        .inp_valid (inp_valid),
        .inp_ready (inp_ready),
        .inp_keep  (inp_keep),
        .inp_id    (inp_id),
        .inp_last  (inp_last),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_keep  (out_keep),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        beat_t b;
        if (reset_n && out_valid && out_ready) begin
            b.data = out;
            b.keep = out_keep;
            b.id   = out_id;
            b.last = out_last;
            got.push_back(b);
        end
        if (cnt_en && reset_n && !inp_ready) low_cnt++;
    end

    always begin
        @(posedge clock);
        #1;
        if (!manual) out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    function automatic logic [511:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    function automatic logic [511:0] keep_bytes(input logic [511:0] d, input logic [63:0] k);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    task automatic clear_stim();
        s_data.delete(); s_keep.delete(); s_id.delete(); s_last.delete();
        got.delete(); exp_q.delete();
    endtask

    task automatic add_beat(input logic [511:0] d, input logic [63:0] k,
                            input logic [5:0] id, input logic last);
        s_data.push_back(d); s_keep.push_back(k); s_id.push_back(id); s_last.push_back(last);
    endtask

    // Reference: every data beat is forwarded; a group closes after 4 beats or at last,
    // and emits the XOR of its masked beats with the id of its final beat.
    task automatic build_model();
        logic [511:0] acc;
        int n;
        beat_t b;
        exp_q.delete();
        acc = '0;
        n = 0;
        foreach (s_data[i]) begin
            b.data = s_data[i]; b.keep = s_keep[i]; b.id = s_id[i]; b.last = 1'b0;
            exp_q.push_back(b);
            acc = acc ^ keep_bytes(s_data[i], s_keep[i]);
            n++;
            if (n == 4 || s_last[i]) begin
                b.data = acc; b.keep = '1; b.id = s_id[i]; b.last = s_last[i];
                exp_q.push_back(b);
                acc = '0;
                n = 0;
            end
        end
    endtask

    task automatic drive_beats();
        foreach (s_data[i]) begin
            int t;
            inp_data = s_data[i]; inp_keep = s_keep[i]; inp_id = s_id[i]; inp_last = s_last[i];
            inp_valid = 1'b1;
            t = 0;
            @(negedge clock);
            while (!inp_ready && t < 500) begin
                @(negedge clock);
                t++;
            end
            if (!inp_ready) begin
                checks++; errors++;
                $display("FAIL drive_timeout: beat %0d not accepted after %0d cycles, required acceptance", i, t);
            end
            @(posedge clock);
            #1;
            inp_valid = 1'b0;
            if (gap_en) repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        inp_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (got.size() < exp_q.size() && t < 2000) begin
            @(negedge clock);
            t++;
        end
        repeat (8) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; inp_valid = 1'b0; inp_data = '0; inp_keep = '0; inp_id = '0; inp_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h required 0", out); end
        checks++; if (out_keep !== '0) begin errors++; $display("FAIL reset_out_keep: got %h required 0", out_keep); end
        checks++; if (out_id !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_id_last: got id=%0d last=%b required 0/0", out_id, out_last); end
        checks++; if (inp_ready !== 1'b0) begin errors++; $display("FAIL reset_inp_ready: got %b required 0", inp_ready); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (inp_ready !== 1'b1) begin errors++; $display("FAIL release_inp_ready: got %b required 1", inp_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_four();
        beat_t g;
        clear_stim();
        for (int k = 1; k <= 4; k++) add_beat(fill(8'(k)), '1, 6'd5, k == 4);
        build_model();
        low_cnt = 0; cnt_en = 1;
        drive_beats();
        wait_drain();
        cnt_en = 0;
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL four_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL four_beat %0d: got id=%0d last=%b keep=%h data=%h required id=%0d last=%b keep=%h data=%h", i, got[i].id, got[i].last, got[i].keep, got[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].keep, exp_q[i].data); end
        end
        g = (got.size() > 4) ? got[4] : '0;
        checks++; if (g !== {fill(8'h04), 64'hFFFF_FFFF_FFFF_FFFF, 6'd5, 1'b1}) begin errors++; $display("FAIL four_csum: got id=%0d last=%b data=%h required id=5 last=1 data all 04", g.id, g.last, g.data); end
        checks++; if (low_cnt !== 1) begin errors++; $display("FAIL four_ready_low: got %0d cycles required 1", low_cnt); end
    endtask

    task automatic test_two();
        beat_t g1, g2;
        clear_stim();
        add_beat(fill(8'hA5), '1, 6'd1, 1'b0);
        add_beat(fill(8'h0F), '1, 6'd2, 1'b1);
        build_model();
        drive_beats();
        wait_drain();
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL two_count: got %0d beats required 3", got.size()); end
        g1 = (got.size() > 1) ? got[1] : '0;
        g2 = (got.size() > 2) ? got[2] : '0;
        checks++; if (g1.last !== 1'b0 || g1.data !== fill(8'h0F)) begin errors++; $display("FAIL two_data2: got last=%b data=%h required last=0 data all 0F", g1.last, g1.data); end
        checks++; if (g2 !== {fill(8'hAA), 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 1'b1}) begin errors++; $display("FAIL two_csum: got id=%0d last=%b data=%h required id=2 last=1 data all AA", g2.id, g2.last, g2.data); end
    endtask

    task automatic test_one_keep();
        beat_t g;
        logic [511:0] e;
        clear_stim();
        add_beat(fill(8'hFF), 64'h1, 6'd33, 1'b1);
        build_model();
        drive_beats();
        wait_drain();
        e = '0;
        e[7:0] = 8'hFF;
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL one_count: got %0d beats required 2", got.size()); end
        g = (got.size() > 1) ? got[1] : '0;
        checks++; if (g !== {e, 64'hFFFF_FFFF_FFFF_FFFF, 6'd33, 1'b1}) begin errors++; $display("FAIL one_csum: got keep=%h last=%b data=%h required keep all ones last=1 data=%h", g.keep, g.last, g.data, e); end
    endtask

    task automatic test_nine();
        int nlast;
        clear_stim();
        for (int k = 1; k <= 9; k++) add_beat(fill(8'(k)), '1, 6'(k), k == 9);
        build_model();
        drive_beats();
        wait_drain();
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL nine_count: got %0d beats required 12", got.size()); end
        if (got.size() >= 12) begin
            checks++; if (got[4].data !== fill(8'h04)) begin errors++; $display("FAIL nine_csum1: got %h required all 04", got[4].data); end
            checks++; if (got[9].data !== fill(8'h0C)) begin errors++; $display("FAIL nine_csum2: got %h required all 0C", got[9].data); end
            checks++; if (got[11].data !== fill(8'h09) || got[11].last !== 1'b1) begin errors++; $display("FAIL nine_csum3: got last=%b data=%h required last=1 all 09", got[11].last, got[11].data); end
        end
        nlast = 0;
        foreach (got[i]) if (got[i].last) nlast++;
        checks++; if (nlast !== 1) begin errors++; $display("FAIL nine_last_count: got %0d last beats required 1", nlast); end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL nine_beat %0d: got id=%0d last=%b data=%h required id=%0d last=%b data=%h", i, got[i].id, got[i].last, got[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data); end
        end
    endtask

    task automatic stall_window(input string tag);
        beat_t snap;
        out_ready = 1'b0;
        snap = {out, out_keep, out_id, out_last};
        repeat (3) begin
            @(negedge clock);
            checks++; if ({out, out_keep, out_id, out_last} !== snap || out_valid !== 1'b1) begin errors++; $display("FAIL %s_stable: got valid=%b id=%0d last=%b data=%h required valid=1 id=%0d last=%b data=%h", tag, out_valid, out_id, out_last, out, snap.id, snap.last, snap.data); end
            checks++; if (inp_ready !== 1'b0) begin errors++; $display("FAIL %s_inp_ready: got %b required 0", tag, inp_ready); end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
    endtask

    task automatic stall_seq();
        int t;
        t = 0;
        @(posedge clock); #1;
        while (got.size() < 1 && t < 200) begin @(posedge clock); #1; t++; end
        stall_window("stall_data");
        t = 0;
        while (!(got.size() >= 4 && out_valid) && t < 200) begin @(posedge clock); #1; t++; end
        checks++; if (out_keep !== 64'hFFFF_FFFF_FFFF_FFFF || out_last !== 1'b1) begin errors++; $display("FAIL stall_csum_present: got keep=%h last=%b required all ones / 1", out_keep, out_last); end
        stall_window("stall_csum");
    endtask

    task automatic test_stall();
        clear_stim();
        for (int k = 0; k < 4; k++) add_beat(rand_data(), '1, 6'd9, k == 3);
        build_model();
        manual = 1;
        out_ready = 1'b1;
        fork
            drive_beats();
            stall_seq();
        join
        wait_drain();
        manual = 0;
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat %0d: got id=%0d last=%b data=%h required id=%0d last=%b data=%h", i, got[i].id, got[i].last, got[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data); end
        end
    endtask

    task automatic test_reset_mid();
        beat_t g;
        clear_stim();
        add_beat(rand_data(), '1, 6'd3, 1'b0);
        add_beat(rand_data(), '1, 6'd3, 1'b0);
        drive_beats();
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out !== '0 || out_keep !== '0 || out_id !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got valid=%b keep=%h id=%0d last=%b data=%h required all zero", out_valid, out_keep, out_id, out_last, out); end
        checks++; if (inp_ready !== 1'b0) begin errors++; $display("FAIL midreset_inp_ready: got %b required 0", inp_ready); end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        clear_stim();
        for (int k = 0; k < 4; k++) add_beat(fill(8'h11), '1, 6'd7, k == 3);
        build_model();
        drive_beats();
        wait_drain();
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL midreset_count: got %0d beats required 5", got.size()); end
        g = (got.size() > 4) ? got[4] : '1;
        checks++; if (g !== {512'h0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd7, 1'b1}) begin errors++; $display("FAIL midreset_csum: got id=%0d last=%b data=%h required id=7 last=1 data 0", g.id, g.last, g.data); end
    endtask

    task automatic test_random();
        clear_stim();
        for (int p = 0; p < 20; p++) begin
            int n;
            logic [5:0] id;
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                logic [63:0] keep;
                case ($urandom_range(0, 3))
                    0: keep = '0;
                    1: keep = {$urandom, $urandom};
                    default: keep = '1;
                endcase
                id = 6'($urandom);
                add_beat(rand_data(), keep, id, k == n - 1);
            end
        end
        build_model();
        rand_bp = 1; gap_en = 1;
        drive_beats();
        wait_drain();
        rand_bp = 0; gap_en = 0;
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat %0d: got id=%0d last=%b keep=%h data=%h required id=%0d last=%b keep=%h data=%h", i, got[i].id, got[i].last, got[i].keep, got[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].keep, exp_q[i].data); end
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        test_reset();
        test_four();
        test_two();
        test_one_keep();
        test_nine();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
